// File: rtl/instruction_memory_responder.sv
// Fetch responder: in-order instruction return after a fixed read latency, through a
// credit-guarded output FIFO, with branch-redirect flush and a program-load write port.
module instruction_memory_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,
   parameter int OUT_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_instruction,
   output logic [63:0] resp_addr,
   output logic        resp_fault,
   input  logic        load_en,
   input  logic [63:0] load_addr,
   input  logic [31:0] load_data
);
   localparam int               IDX_W      = $clog2(DEPTH_WORDS);
   localparam int               PTR_W      = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int               CNT_W      = $clog2(OUT_DEPTH + 1);
   localparam logic [63:0]      ADDR_LIMIT = 64'(4 * DEPTH_WORDS);
   localparam logic [31:0]      NOP_INSTR  = 32'hD503201F;
   localparam logic [CNT_W-1:0] CREDITS    = CNT_W'(OUT_DEPTH);

   logic [31:0]          mem [DEPTH_WORDS];
   logic [31:0]          fifo_instr [OUT_DEPTH];
   logic [63:0]          fifo_addr  [OUT_DEPTH];
   logic [OUT_DEPTH-1:0] fifo_fault;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     fifo_count, outstanding;
   logic [31:0]          hold_instr;
   logic [63:0]          hold_addr;
   logic                 hold_fault;
   logic                 accept, push, pop;
   logic                 vld_p0, fault_p0;
   logic [31:0]          instr_p0;
   logic [63:0]          addr_p0;
   logic                 vld_tail, fault_tail;
   logic [31:0]          instr_tail;
   logic [63:0]          addr_tail;

   function automatic logic bad_addr(input logic [63:0] a);
      return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credits count every accepted request until its response is popped, so a push can never overflow.
   assign req_ready = !flush && (outstanding < CREDITS);
   assign accept    = req_valid && req_ready;

   // Stage p0: accept cycle, array read (old data wins over a same-cycle load)
   assign vld_p0   = accept;
   assign addr_p0  = req_addr;
   assign fault_p0 = bad_addr(req_addr);
   assign instr_p0 = fault_p0 ? NOP_INSTR : mem[req_addr[IDX_W+1:2]];

   always_ff @(posedge clock) begin
      if (load_en && !bad_addr(load_addr))
         mem[load_addr[IDX_W+1:2]] <= load_data;
   end

   // Stages p1..p(LATENCY-1): delay line; its last stage feeds the FIFO
   generate
      if (LATENCY > 1) begin : g_pipe
         logic        vld_pn   [LATENCY-1];
         logic        fault_pn [LATENCY-1];
         logic [31:0] instr_pn [LATENCY-1];
         logic [63:0] addr_pn  [LATENCY-1];

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int j = 0; j < LATENCY - 1; j++) vld_pn[j] <= 1'b0;
            end else begin
               vld_pn[0] <= flush ? 1'b0 : vld_p0;
               for (int j = 1; j < LATENCY - 1; j++) vld_pn[j] <= flush ? 1'b0 : vld_pn[j-1];
            end
         end

         always_ff @(posedge clock) begin
            instr_pn[0] <= instr_p0;
            addr_pn[0]  <= addr_p0;
            fault_pn[0] <= fault_p0;
            for (int j = 1; j < LATENCY - 1; j++) begin
               instr_pn[j] <= instr_pn[j-1];
               addr_pn[j]  <= addr_pn[j-1];
               fault_pn[j] <= fault_pn[j-1];
            end
         end

         assign vld_tail   = vld_pn[LATENCY-2];
         assign instr_tail = instr_pn[LATENCY-2];
         assign addr_tail  = addr_pn[LATENCY-2];
         assign fault_tail = fault_pn[LATENCY-2];
      end else begin : g_direct
         assign vld_tail   = vld_p0;
         assign instr_tail = instr_p0;
         assign addr_tail  = addr_p0;
         assign fault_tail = fault_p0;
      end
   endgenerate

   // Output FIFO and credit bookkeeping
   assign push       = vld_tail && !flush;
   assign resp_valid = (fifo_count != '0);
   assign pop        = resp_valid && resp_ready && !flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_instr[wr_ptr] <= instr_tail;
         fifo_addr[wr_ptr]  <= addr_tail;
         fifo_fault[wr_ptr] <= fault_tail;
      end
   end

   // Last presented head is kept so the outputs hold while the FIFO is empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_instr <= '0;
         hold_addr  <= '0;
         hold_fault <= 1'b0;
      end else if (resp_valid) begin
         hold_instr <= fifo_instr[rd_ptr];
         hold_addr  <= fifo_addr[rd_ptr];
         hold_fault <= fifo_fault[rd_ptr];
      end
   end

   assign resp_instruction = resp_valid ? fifo_instr[rd_ptr] : hold_instr;
   assign resp_addr        = resp_valid ? fifo_addr[rd_ptr]  : hold_addr;
   assign resp_fault       = resp_valid ? fifo_fault[rd_ptr] : hold_fault;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench for instruction_memory_responder: directed requests queue their
// expected responses; a negedge monitor pops and compares every delivered response.
module tb_instruction_memory_responder;
   localparam int LAT = 2;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instruction;
   logic [63:0] resp_addr;
   logic        resp_fault;
   logic        load_en;
   logic [63:0] load_addr;
   logic [31:0] load_data;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] addr;
      logic        fault;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   instruction_memory_responder #(
      .DEPTH_WORDS(256), .LATENCY(LAT), .OUT_DEPTH(4)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_instruction(resp_instruction), .resp_addr(resp_addr), .resp_fault(resp_fault),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One request cycle; expected ready is hand-given, accepted requests are queued.
   task automatic req(input logic [63:0] a, input logic [31:0] ei, input logic ef,
                      input logic er, input bit timed);
      req_valid = 1'b1;
      req_addr  = a;
      #1;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (er) sb.push_back('{ei, a, ef, (timed ? cyc + LAT : -1)});
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic load(input logic [63:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d responses still owed, want 0", sb.size());
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && !flush && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got addr %h instr %h, want no response",
                        resp_addr, resp_instruction);
            end else begin
               e = sb.pop_front();
               chk("resp_instruction", 64'(resp_instruction), 64'(e.instr));
               chk("resp_addr", resp_addr, e.addr);
               chk("resp_fault", 64'(resp_fault), 64'(e.fault));
               if (e.cyc >= 0) chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      load_en    = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_resp_instruction", 64'(resp_instruction), 64'(0));
      chk("rst_resp_addr", resp_addr, 64'(0));
      chk("rst_resp_fault", 64'(resp_fault), 64'(0));
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 64'(req_ready), 64'(1));
      step();

      // Program load, then back-to-back fetches with full throughput
      load(64'h0, 32'h91000421);
      load(64'h4, 32'h8B020020);
      load(64'h8, 32'hF9400041);
      load(64'hC, 32'hD65F03C0);
      req(64'h0, 32'h91000421, 1'b0, 1'b1, 1'b1);
      req(64'h4, 32'h8B020020, 1'b0, 1'b1, 1'b1);
      req(64'h8, 32'hF9400041, 1'b0, 1'b1, 1'b1);
      req(64'hC, 32'hD65F03C0, 1'b0, 1'b1, 1'b1);
      drain();

      // Back-pressure: four credits, stable head, credit returns a cycle after the pop
      resp_ready = 1'b0;
      req(64'h0, 32'h91000421, 1'b0, 1'b1, 1'b0);
      req(64'h4, 32'h8B020020, 1'b0, 1'b1, 1'b0);
      req(64'h8, 32'hF9400041, 1'b0, 1'b1, 1'b0);
      req(64'hC, 32'hD65F03C0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1;
         req_addr  = 64'h0;
         #1;
         chk("ready_when_full", 64'(req_ready), 64'(0));
         chk("head_valid", 64'(resp_valid), 64'(1));
         chk("head_stable", 64'(resp_instruction), 64'(32'h91000421));
         step();
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      #1;
      chk("ready_same_cycle_as_pop", 64'(req_ready), 64'(0));
      step();
      chk("ready_after_pop", 64'(req_ready), 64'(1));
      drain();

      // Faulting addresses: misaligned and out of range
      req(64'h6, 32'hD503201F, 1'b1, 1'b1, 1'b1);
      req(64'h400, 32'hD503201F, 1'b1, 1'b1, 1'b1);
      drain();

      // Flush with three in flight and a concurrent request
      resp_ready = 1'b0;
      req(64'h0, 32'h91000421, 1'b0, 1'b1, 1'b0);
      req(64'h4, 32'h8B020020, 1'b0, 1'b1, 1'b0);
      req(64'h8, 32'hF9400041, 1'b0, 1'b1, 1'b0);
      flush      = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 64'hC;
      resp_ready = 1'b1;
      #1;
      chk("ready_during_flush", 64'(req_ready), 64'(0));
      sb.delete();
      step();
      flush     = 1'b0;
      req_valid = 1'b0;
      chk("valid_after_flush", 64'(resp_valid), 64'(0));
      req(64'h8, 32'hF9400041, 1'b0, 1'b1, 1'b1);
      drain();

      // Read-before-write on a same-cycle load to the same word
      load_en   = 1'b1;
      load_addr = 64'h4;
      load_data = 32'hAAAAAAAA;
      req(64'h4, 32'h8B020020, 1'b0, 1'b1, 1'b1);
      load_en = 1'b0;
      req(64'h4, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1);
      drain();

      // Asynchronous reset with one buffered and more in flight
      resp_ready = 1'b0;
      req(64'h0, 32'h91000421, 1'b0, 1'b1, 1'b0);
      req(64'h8, 32'hF9400041, 1'b0, 1'b1, 1'b0);
      req_valid = 1'b1;
      req_addr  = 64'hC;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 64'(resp_valid), 64'(0));
      chk("async_rst_instruction", 64'(resp_instruction), 64'(0));
      chk("async_rst_addr", resp_addr, 64'(0));
      chk("async_rst_fault", 64'(resp_fault), 64'(0));
      sb.delete();
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("ready_after_async_rst", 64'(req_ready), 64'(1));
      repeat (6) step();
      chk("no_stale_after_rst", 64'(resp_valid), 64'(0));
      req(64'hC, 32'hD65F03C0, 1'b0, 1'b1, 1'b1);
      drain();

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
